// File: rtl/prbs_checker.sv
// Self-synchronizing PRBS checker: locks after Width+LockCount clean bits, then flywheels and counts errors.
// Outputs are registered one edge after the consuming bit; en_i qualifies each bit and cannot be backpressured.
module prbs_checker #(
   parameter int               Width     = 5,
   parameter logic [Width-1:0] Taps      = 5'b10100,
   parameter int               LockCount = 8,
   parameter int               LossCount = 4,
   parameter int               CntWidth  = 16
) (
   input  logic                clk_i,
   input  logic                rst_i,
   input  logic                en_i,
   input  logic                rnd_i,
   input  logic                clr_i,
   output logic                locked_o,
   output logic                err_o,
   output logic [CntWidth-1:0] err_cnt_o,
   output logic [Width-1:0]    q_o
);

   localparam int FW = $clog2(Width + 1);

   typedef enum logic [1:0] {HUNT = 2'd0, VERIFY = 2'd1, LOCKED = 2'd2} state_t;

   state_t              state, state_nx;
   logic [Width-1:0]    h;
   logic [FW-1:0]       fill;
   logic [7:0]          match_cnt;
   logic [7:0]          miss_cnt;
   logic [CntWidth-1:0] err_cnt;
   logic                err;
   logic                pred;
   logic                miss;
   logic                hit_err;

   assign pred    = ^(h & Taps);
   assign miss    = rnd_i != pred;
   assign hit_err = en_i && (state == LOCKED) && miss;

   always_ff @(posedge clk_i) begin
      if (rst_i) state <= HUNT;
      else       state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      if (en_i) begin
         unique case (state)
            HUNT:    if (fill == FW'(Width - 1)) state_nx = VERIFY;
            VERIFY:  if (!miss && h != '0 && match_cnt == 8'(LockCount - 1)) state_nx = LOCKED;
            LOCKED:  if (miss && miss_cnt == 8'(LossCount - 1)) state_nx = HUNT;
            default: state_nx = HUNT;
         endcase
      end
   end

   always_comb begin
      locked_o  = (state == LOCKED);
      err_o     = err;
      err_cnt_o = err_cnt;
      q_o       = h;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         h         <= '0;
         fill      <= '0;
         match_cnt <= '0;
         miss_cnt  <= '0;
         err       <= 1'b0;
         err_cnt   <= '0;
      end else begin
         err <= hit_err;
         if (clr_i)                           err_cnt <= hit_err ? CntWidth'(1) : '0;
         else if (hit_err && err_cnt != '1)   err_cnt <= err_cnt + 1'b1;

         if (en_i) begin
            // Once locked, shift our own prediction so line errors never corrupt the reference.
            h <= {h[Width-2:0], (state == LOCKED) ? pred : rnd_i};
            case (state)
               HUNT: begin
                  fill      <= fill + 1'b1;
                  match_cnt <= '0;
               end
               VERIFY: begin
                  match_cnt <= (!miss && h != '0) ? match_cnt + 8'd1 : 8'd0;
                  miss_cnt  <= '0;
               end
               LOCKED: begin
                  miss_cnt <= miss ? miss_cnt + 8'd1 : 8'd0;
                  if (state_nx == HUNT) fill <= '0;
               end
               default: fill <= '0;
            endcase
         end
      end
   end

endmodule

// File: doc/prbs_checker.md
# prbs_checker

Serial pseudo-random bit-stream checker: the receive-side counterpart of the team's `lfsr` generator. It self-synchronizes to an incoming Fibonacci-LFSR bit stream, declares lock after a run of correct predictions, then flywheels on its own prediction to count bit errors. It sits at the far end of a link or loopback under test, fed one bit per enabled clock.

## Interface

Parameters:
- `Width`, 5: LFSR degree, which is also the history register width.
- `Taps`, 5'b10100: feedback mask over the history register. Default is x^5+x^3+1, maximal length, period 31.
- `LockCount`, 8: consecutive correct predictions needed to lock. Legal range 1..255.
- `LossCount`, 4: consecutive mismatches while locked that drop lock. Legal range 1..255.
- `CntWidth`, 16: width of the error counter.

Ports:
- `clk_i`, input, 1: single clock. All logic is on the rising edge.
- `rst_i`, input, 1: reset, synchronous and active-high.
- `en_i`, input, 1: bit-valid qualifier. `rnd_i` is consumed only on edges where `en_i`=1.
- `rnd_i`, input, 1: received serial bit.
- `clr_i`, input, 1: synchronous clear of `err_cnt_o`. It does not need `en_i`.
- `locked_o`, output, 1: checker is locked to the sequence.
- `err_o`, output, 1: one-cycle pulse on each bit error detected while locked.
- `err_cnt_o`, output, CntWidth: saturating count of bit errors.
- `q_o`, output, Width: history register, for debug.

## Operation

History register `h`:
- Bit 0 holds the newest bit. `h[i]` holds the bit received i+1 accepted bits ago.
- Predicted bit: `p = ^(h & Taps)`. For the defaults this is b[n] = b[n-5] ^ b[n-3].
- Shift on an accepted bit: `h <= {h[Width-2:0], x}`.
  - In HUNT and VERIFY, x = `rnd_i`.
  - In LOCKED, x = `p` (flywheel), so received errors never corrupt the prediction.

FSM. Every transition happens only on an edge with `en_i`=1.
- **HUNT**
  - Shift in `rnd_i` and increment the fill counter.
  - When the Width-th bit is accepted: go to VERIFY, match_cnt=0.
- **VERIFY**
  - `rnd_i`==p and h != 0: match_cnt++.
  - If the incremented match_cnt reaches LockCount: go to LOCKED and set `locked_o`=1.
  - `rnd_i`!=p: match_cnt=0 and stay in VERIFY. The register has re-seeded itself from the new bit.
  - h==0: the match is not counted and match_cnt is held at 0. An all-zero stream must never lock.
- **LOCKED**
  - `rnd_i`!=p: `err_o` pulses, `err_cnt_o`++ (saturating at all-ones), miss_cnt++.
  - `rnd_i`==p: miss_cnt=0.
  - miss_cnt reaching LossCount: go to HUNT, fill counter=0, `locked_o`=0, and reload h from `rnd_i` as normal HUNT shifting.
  - The error count includes the LossCount-th miss.

Rules that apply in every state:
- `err_o` and `err_cnt_o` change only in LOCKED. Mismatches in HUNT and VERIFY are not errors.
- `clr_i` and an error on the same edge: `err_cnt_o` becomes 1.
- `clr_i` alone: `err_cnt_o` becomes 0.
- `en_i`=0: no state, counter or history change, and `err_o`=0.

## Timing

- All outputs are registered. Output changes appear after the edge that consumed the qualifying bit.
- Reset (`rst_i`=1 at an edge) has priority over everything, including mid-lock:
  - state=HUNT; fill counter, match_cnt and miss_cnt=0.
  - h=0, `q_o`=0.
  - `locked_o`=0, `err_o`=0, `err_cnt_o`=0.
- Minimum lock latency from reset on a clean stream: Width+LockCount accepted bits. With the defaults, `locked_o` rises after the edge that accepts the 13th bit.
- `err_o` is high for exactly the one cycle after the erroneous bit's edge. Back-to-back errors on consecutive enabled cycles give `err_o` held high.
- With gaps in `en_i`, latency is counted in accepted bits, not in cycles.

## Test plan

- **Clean lock.** Reset, then feed the default `lfsr` output with `en_i`=1 continuously.
  - `locked_o`=1 after the 13th accepted bit.
  - `err_cnt_o` stays 0 across 100 bits.
- **Single error.** When locked, invert one bit.
  - `err_o` high for exactly one cycle.
  - `err_cnt_o`=1, `locked_o` stays 1.
  - The next 31 bits add no further errors, which shows the flywheel.
- **Loss of lock.** When locked, invert 4 consecutive bits.
  - `err_cnt_o`=4 and `locked_o` drops after the 4th.
  - Resume the clean stream: relock after 13 further accepted bits.
- **All-zero stream.** Reset, then feed 50 zeros.
  - `locked_o` stays 0 and `err_cnt_o`=0.
- **Enable gaps and clear.** Toggle `en_i` every other cycle on a clean stream.
  - Lock occurs after 13 accepted bits, which is 26 cycles.
  - Inject an error while asserting `clr_i` on the same edge: `err_cnt_o`=1.
- **Reset mid-lock.** Assert `rst_i` for one edge while locked with `err_cnt_o`=3.
  - All outputs go to 0.
  - Relock after 13 accepted bits.
